// File: rtl/l1_memory_latency_module.sv
// Byte-banked L1 memory model with a fixed read latency enforced by a stall FSM.
// Optional one-word hit buffer is built when L1_MEM_HIT_BUFFER_EN is defined.
module l1_memory_latency_module #(
  parameter int LOGICAL_ADD_WIDTH = 9,
  parameter int DATA_WIDTH        = 32,
  parameter int READ_LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    read_en,
  input  logic [31:0]             read_addr,
  input  logic                    write_en,
  input  logic [31:0]             write_addr,
  input  logic [DATA_WIDTH/8-1:0] write_mask,
  input  logic [DATA_WIDTH-1:0]   write_data,
  output logic [DATA_WIDTH-1:0]   read_data,
  output logic                    stall
);
  localparam int LANES = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(LANES);
  localparam int IDX_W = LOGICAL_ADD_WIDTH - OFS;
  localparam int DEPTH = 1 << IDX_W;
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_next;
  logic [CNT_W-1:0]      lat_cnt;
  logic [IDX_W-1:0]      lat_idx, rd_idx, wr_idx;
  logic [DATA_WIDTH-1:0] resp_word, hit_data;
  logic                  hit, start, unused_addr;

  assign rd_idx      = read_addr[LOGICAL_ADD_WIDTH-1:OFS];
  assign wr_idx      = write_addr[LOGICAL_ADD_WIDTH-1:OFS];
  assign unused_addr = ^{read_addr, write_addr};
  assign start       = (state == IDLE) && read_en && !hit;

  // One bank per byte lane; contents are deliberately not reset.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [7:0] bank [DEPTH];
    always_ff @(posedge clk) begin
      if (!reset && write_en && write_mask[g])
        bank[wr_idx] <= write_data[8*g +: 8];
    end
    assign resp_word[8*g +: 8] = bank[lat_idx];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
      lat_idx <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        lat_cnt <= CNT_W'(READ_LATENCY - 1);
        lat_idx <= rd_idx;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (READ_LATENCY > 1) ? WAIT : RESP;
      WAIT: begin
        if (!read_en)                  state_next = IDLE;
        else if (lat_cnt == CNT_W'(1)) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    read_data = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (hit)          read_data = hit_data;
          else if (read_en) stall     = 1'b1;
        end
        WAIT:    stall = read_en;
        RESP:    if (read_en) read_data = resp_word;
        default: stall = 1'b0;
      endcase
    end
  end

`ifdef L1_MEM_HIT_BUFFER_EN
  logic                  buf_valid, done;
  logic [IDX_W-1:0]      buf_idx, fill_idx;
  logic [DATA_WIDTH-1:0] buf_data, buf_next;

  assign done     = (state == RESP) && read_en;
  assign fill_idx = done ? lat_idx : buf_idx;
  assign hit      = (state == IDLE) && read_en && buf_valid && (buf_idx == rd_idx);
  assign hit_data = buf_data;

  // Same-cycle writes are merged into the entry so it never goes stale.
  always_comb begin
    buf_next = done ? resp_word : buf_data;
    if (write_en && (wr_idx == fill_idx)) begin
      for (int i = 0; i < LANES; i++)
        if (write_mask[i]) buf_next[8*i +: 8] = write_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
    end else begin
      if (done) begin
        buf_valid <= 1'b1;
        buf_idx   <= lat_idx;
      end
      buf_data <= buf_next;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

endmodule
